retire_trace_pipe: RTL

- Synthesizable shadow pipeline that carries PC, instruction and decode fields from fetch through issue, execute, memory and write-back, alongside the MIPS 5-stage core.
- Presents one retirement record per retired instruction to the ISA-model comparison logic.
- Honours core stall and flush, counts retirements, and raises sticky end-of-test and type-error flags.
- Sits between the core's fetch/issue/write-back probe points and the retirement checker.

---
 rtl/retire_trace_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/retire_trace_pipe.sv
// retire_trace_pipe - shadow ISS/EX/MEM/WB trace pipeline that presents one retirement record per retired instruction
// Also tracks the retirement count, the sticky end-of-test flag and the sticky decode-type-error flag.
module retire_trace_pipe #(
  parameter int                XLEN      = 32,
  parameter int                CNT_W     = 32,
  parameter logic [XLEN-1:0]   END_INSTR = 'h0000000c,
  parameter logic [XLEN-1:0]   END_V0    = 'h0000000a
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [XLEN-1:0]   pc_fetch,
  input  logic [XLEN-1:0]   instr_fetch,
  input  logic              stall_iss,
  input  logic              flush,
  input  logic              is_r_type_iss,
  input  logic              is_i_type_iss,
  input  logic              is_j_type_iss,
  input  logic [4:0]        rd_iss,
  input  logic [4:0]        rs_iss,
  input  logic [4:0]        rt_iss,
  input  logic              reg_wr_wb,
  input  logic [XLEN-1:0]   wr_data_wb,
  input  logic [XLEN-1:0]   v0_val,
  output logic              retire_valid,
  output logic [XLEN-1:0]   pc_ret,
  output logic [XLEN-1:0]   instr_ret,
  output logic              is_r_type_ret,
  output logic              is_i_type_ret,
  output logic              is_j_type_ret,
  output logic [4:0]        rd_ret,
  output logic [4:0]        rs_ret,
  output logic [4:0]        rt_ret,
  output logic              dest_wr_ret,
  output logic [XLEN-1:0]   dest_val_ret,
  output logic [CNT_W-1:0]  retire_count,
  output logic              sim_done,
  output logic              type_err
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            r_type;
    logic            i_type;
    logic            j_type;
    logic [4:0]      rd;
    logic [4:0]      rs;
    logic [4:0]      rt;
  } rec_t;

  logic            iss_valid_q, iss_valid_d;
  logic [XLEN-1:0] iss_pc_q, iss_pc_d;
  logic [XLEN-1:0] iss_instr_q, iss_instr_d;
  rec_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic             sim_done_q, sim_done_d;
  logic             type_err_q, type_err_d;
  logic [1:0]       type_cnt;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_pc_d    = iss_pc_q;
    iss_instr_d = iss_instr_q;
    ex_d        = ex_q;
    mem_d       = ex_q;
    wb_d        = mem_q;
    // A flushed EX record still shifts down but must never retire.
    mem_d.valid = ex_q.valid & ~flush;
    if (flush) begin
      iss_valid_d = 1'b0;
      ex_d        = '0;
    end else if (stall_iss) begin
      ex_d = '0;
    end else begin
      iss_valid_d = fetch_valid;
      iss_pc_d    = pc_fetch;
      iss_instr_d = instr_fetch;
      ex_d        = '{valid: iss_valid_q, pc: iss_pc_q, instr: iss_instr_q,
                      r_type: is_r_type_iss, i_type: is_i_type_iss,
                      j_type: is_j_type_iss, rd: rd_iss, rs: rs_iss, rt: rt_iss};
    end
  end

  assign type_cnt = {1'b0, wb_q.r_type} + {1'b0, wb_q.i_type} + {1'b0, wb_q.j_type};

  always_comb begin
    count_d    = count_q;
    sim_done_d = sim_done_q;
    type_err_d = type_err_q;
    if (wb_q.valid) begin
      count_d = count_q + 1'b1;
      if (wb_q.instr == END_INSTR && v0_val == END_V0) sim_done_d = 1'b1;
      if (type_cnt != 2'd1) type_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_pc_q    <= '0;
      iss_instr_q <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      count_q     <= '0;
      sim_done_q  <= 1'b0;
      type_err_q  <= 1'b0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_pc_q    <= iss_pc_d;
      iss_instr_q <= iss_instr_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      count_q     <= count_d;
      sim_done_q  <= sim_done_d;
      type_err_q  <= type_err_d;
    end
  end

  assign retire_valid  = wb_q.valid;
  assign pc_ret        = wb_q.pc;
  assign instr_ret     = wb_q.instr;
  assign is_r_type_ret = wb_q.r_type;
  assign is_i_type_ret = wb_q.i_type;
  assign is_j_type_ret = wb_q.j_type;
  assign rd_ret        = wb_q.rd;
  assign rs_ret        = wb_q.rs;
  assign rt_ret        = wb_q.rt;
  assign dest_wr_ret   = wb_q.valid & reg_wr_wb;
  assign dest_val_ret  = dest_wr_ret ? wr_data_wb : '0;
  assign retire_count  = count_q;
  assign sim_done      = sim_done_q;
  assign type_err      = type_err_q;

endmodule
